// File: rtl/lampfpu_log_postnorm_if.sv
// rtl/lampfpu_log_postnorm_if.sv - result/handshake bundle between log unit, post-norm stage and consumer
interface lampfpu_log_postnorm_if #(
    parameter int E_DW = 8,
    parameter int F_DW = 7
);
    logic                 valid_i;
    logic                 s_i;
    logic [E_DW-1:0]      e_i;
    logic [F_DW+4:0]      f_i;
    logic                 isOverflow_i;
    logic                 isUnderflow_i;
    logic                 isToRound_i;
    logic [E_DW+F_DW:0]   result_o;
    logic                 valid_o;
    logic                 ready_i;
    logic                 isOverflow_o;
    logic                 isInexact_o;
    logic                 full_o;
    logic                 dropErr_o;

    modport slave (
        input  valid_i, s_i, e_i, f_i, isOverflow_i, isUnderflow_i, isToRound_i, ready_i,
        output result_o, valid_o, isOverflow_o, isInexact_o, full_o, dropErr_o
    );

    modport master (
        output valid_i, s_i, e_i, f_i, isOverflow_i, isUnderflow_i, isToRound_i, ready_i,
        input  result_o, valid_o, isOverflow_o, isInexact_o, full_o, dropErr_o
    );
endinterface

// File: rtl/lampfpu_log_postnorm.sv
// rtl/lampfpu_log_postnorm.sv - bfloat16 log post-normalise/round stage with input FIFO and output register
module lampfpu_log_postnorm #(
    parameter int E_DW       = 8,
    parameter int F_DW       = 7,
    parameter int FIFO_DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    lampfpu_log_postnorm_if.slave bus
);
    localparam int M_W   = F_DW + 5;
    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int ENT_W = 1 + E_DW + M_W + 3;
    localparam int R_W   = 1 + E_DW + F_DW;

    logic [ENT_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             full;
    logic             push;
    logic             pop;
    logic             drop_err;

    logic [R_W-1:0]   res_q;
    logic             valid_q;
    logic             ovf_q;
    logic             inx_q;

    // Head entry fields
    logic             hs;
    logic [E_DW-1:0]  he;
    logic [M_W-1:0]   hf;
    logic             hovf;
    logic             hunf;
    logic             hrnd;

    // Rounding datapath
    logic [F_DW:0]    m;
    logic             g;
    logic             t;
    logic             up;
    logic [E_DW:0]    e_x;
    logic [E_DW:0]    e_fin;
    logic [F_DW+1:0]  sum;
    logic [F_DW-1:0]  frac;
    logic [R_W-1:0]   rnd_res;
    logic             rnd_ovf;
    logic             rnd_inx;

    assign full = (count == (AW+1)'(FIFO_DEPTH));
    assign pop  = (count != '0) && (!valid_q || bus.ready_i);
    assign push = bus.valid_i && (!full || pop);

    assign {hs, he, hf, hovf, hunf, hrnd} = mem[rd_ptr];

    // FIFO storage; no reset needed since count gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.s_i, bus.e_i, bus.f_i, bus.isOverflow_i, bus.isUnderflow_i, bus.isToRound_i};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at a power-of-two depth
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + (AW+1)'(1);
            else if (!push && pop) count <= count - (AW+1)'(1);
        end
    end

    // Sticky record of a result lost because the FIFO was full and not draining
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                   drop_err <= 1'b0;
        else if (bus.valid_i && full && !pop)      drop_err <= 1'b1;
    end

    // Normalise, round to nearest-even and pack the head entry
    always_comb begin
        rnd_res = '0;
        rnd_ovf = 1'b0;
        rnd_inx = 1'b0;
        if (hf[M_W-1]) begin
            m   = hf[M_W-1:4];
            g   = hf[3];
            t   = |hf[2:0];
            e_x = {1'b0, he} + (E_DW+1)'(1);
        end else begin
            m   = hf[M_W-2:3];
            g   = hf[2];
            t   = |hf[1:0];
            e_x = {1'b0, he};
        end
        up  = g && (t || m[0]);
        sum = {1'b0, m} + (F_DW+2)'(up);
        if (sum[F_DW+1]) begin
            frac  = '0;
            e_fin = e_x + (E_DW+1)'(1);
        end else begin
            frac  = sum[F_DW-1:0];
            e_fin = e_x;
        end
        if (!hrnd) begin
            rnd_res = {hs, he, hf[M_W-3:3]};
        end else if (hovf) begin
            rnd_res = {hs, {E_DW{1'b1}}, {F_DW{1'b0}}};
            rnd_ovf = 1'b1;
        end else if (hunf) begin
            rnd_res = {hs, {E_DW{1'b0}}, {F_DW{1'b0}}};
            rnd_inx = 1'b1;
        end else begin
            rnd_inx = g || t;
            if (e_fin >= {1'b0, {E_DW{1'b1}}}) begin
                rnd_res = {hs, {E_DW{1'b1}}, {F_DW{1'b0}}};
                rnd_ovf = 1'b1;
            end else begin
                rnd_res = {hs, e_fin[E_DW-1:0], frac};
            end
        end
    end

    // Output register: load on pop, release on handshake, hold while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            inx_q   <= 1'b0;
        end else if (pop) begin
            res_q   <= rnd_res;
            valid_q <= 1'b1;
            ovf_q   <= rnd_ovf;
            inx_q   <= rnd_inx;
        end else if (bus.ready_i && valid_q) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.result_o     = res_q;
    assign bus.valid_o      = valid_q;
    assign bus.isOverflow_o = ovf_q;
    assign bus.isInexact_o  = inx_q;
    assign bus.full_o       = full;
    assign bus.dropErr_o    = drop_err;
endmodule

// File: tb/tb_lampfpu_log_postnorm.sv
// tb/tb_lampfpu_log_postnorm.sv - self-checking bench for lampfpu_log_postnorm
module tb_lampfpu_log_postnorm;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    lampfpu_log_postnorm_if #(.E_DW(8), .F_DW(7)) bus ();

    lampfpu_log_postnorm #(.E_DW(8), .F_DW(7), .FIFO_DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        logic [7:0]  e;
        logic [11:0] f;
        logic        ovf;
        logic        unf;
        logic        rnd;
        logic [15:0] res;
        logic        xovf;
        logic        xinx;
    } vec_t;

    vec_t        tbl [$];
    logic [17:0] sb  [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: value-level round-to-nearest-even, returns {result, ovf, inexact}
    function automatic logic [17:0] model(input logic s, input logic [7:0] e, input logic [11:0] f,
                                          input logic ovf, input logic unf, input logic rnd);
        int   sh, kept, rem, half, ex;
        logic inx;
        if (!rnd) return {s, e, f[9:3], 2'b00};
        if (ovf)  return {s, 8'hFF, 7'd0, 2'b10};
        if (unf)  return {s, 15'd0, 2'b01};
        sh   = f[11] ? 4 : 3;
        kept = int'(f) >> sh;
        rem  = int'(f) % (1 << sh);
        half = 1 << (sh - 1);
        inx  = (rem != 0);
        if (rem > half || (rem == half && (kept % 2) == 1)) kept = kept + 1;
        ex = int'(e) + sh - 3;
        if (kept >= 256) begin
            kept = kept / 2;
            ex   = ex + 1;
        end
        if (ex >= 255) return {s, 8'hFF, 7'd0, 1'b1, inx};
        return {s, 8'(ex), 7'(kept % 128), 1'b0, inx};
    endfunction

    task automatic drive(input logic v, input logic s, input logic [7:0] e, input logic [11:0] f,
                         input logic ovf, input logic unf, input logic rnd);
        bus.valid_i       = v;
        bus.s_i           = s;
        bus.e_i           = e;
        bus.f_i           = f;
        bus.isOverflow_i  = ovf;
        bus.isUnderflow_i = unf;
        bus.isToRound_i   = rnd;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [17:0] exp_v;
        int          pending;
        logic        drop_model;
        logic        rdy, vld;

        drive(0, 0, 0, 0, 0, 0, 0);
        bus.ready_i = 1'b1;

        tbl.push_back('{1'b0, 8'd127, 12'b01_0000000_000, 1'b0, 1'b0, 1'b1, 16'h3F80, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 8'd127, 12'b01_0000001_100, 1'b0, 1'b0, 1'b1, 16'h3F82, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 8'd127, 12'b01_0000000_100, 1'b0, 1'b0, 1'b1, 16'h3F80, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 8'd127, 12'b01_1111111_110, 1'b0, 1'b0, 1'b1, 16'h4000, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 8'd127, 12'b10_0000000_000, 1'b0, 1'b0, 1'b1, 16'h4000, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 8'd254, 12'b01_1111111_111, 1'b0, 1'b0, 1'b1, 16'h7F80, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 8'hFF,  12'b01_1000000_000, 1'b0, 1'b0, 1'b0, 16'h7FC0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 8'd127, 12'b01_0000000_000, 1'b1, 1'b0, 1'b1, 16'hFF80, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 8'd3,   12'b01_0101010_101, 1'b0, 1'b1, 1'b1, 16'h8000, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 8'h80,  12'b01_0000011_111, 1'b1, 1'b1, 1'b0, 16'h4003, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 8'd254, 12'b10_0000000_000, 1'b0, 1'b0, 1'b1, 16'h7F80, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 8'd100, 12'b01_0101010_011, 1'b0, 1'b0, 1'b1, 16'hB22A, 1'b0, 1'b1});

        // Reset values while rst is held
        #3;
        check("rst_result", bus.result_o, 0);
        check("rst_valid", bus.valid_o, 0);
        check("rst_ovf", bus.isOverflow_o, 0);
        check("rst_inx", bus.isInexact_o, 0);
        check("rst_full", bus.full_o, 0);
        check("rst_drop", bus.dropErr_o, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors, two-edge latency with ready held high
        for (int i = 0; i < tbl.size(); i++) begin
            drive(1, tbl[i].s, tbl[i].e, tbl[i].f, tbl[i].ovf, tbl[i].unf, tbl[i].rnd);
            step();
            bus.valid_i = 1'b0;
            check($sformatf("v%0d_lat1_valid", i), bus.valid_o, 0);
            step();
            check($sformatf("v%0d_valid", i), bus.valid_o, 1);
            check($sformatf("v%0d_result", i), bus.result_o, tbl[i].res);
            check($sformatf("v%0d_ovf", i), bus.isOverflow_o, tbl[i].xovf);
            check($sformatf("v%0d_inx", i), bus.isInexact_o, tbl[i].xinx);
        end
        step();

        // Backpressure: three results held, fourth dropped
        bus.ready_i = 1'b0;
        for (int j = 0; j < 4; j++) begin
            drive(1, 0, 8'(127 + j), 12'h400, 0, 0, 1);
            step();
            if (j == 2) begin
                check("bp_full", bus.full_o, 1);
                check("bp_nodrop", bus.dropErr_o, 0);
            end
            if (j == 3) check("bp_drop", bus.dropErr_o, 1);
        end
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        check("bp_out0_valid", bus.valid_o, 1);
        check("bp_out0", bus.result_o, 16'h3F80);
        step();
        check("bp_out1_valid", bus.valid_o, 1);
        check("bp_out1", bus.result_o, 16'h4000);
        step();
        check("bp_out2_valid", bus.valid_o, 1);
        check("bp_out2", bus.result_o, 16'h4080);
        step();
        check("bp_empty", bus.valid_o, 0);
        check("bp_drop_sticky", bus.dropErr_o, 1);
        check("bp_notfull", bus.full_o, 0);

        // Asynchronous reset while stalled with output register and FIFO occupied
        bus.ready_i = 1'b0;
        for (int j = 0; j < 3; j++) begin
            drive(1, 0, 8'(140 + j), 12'h400, 0, 0, 1);
            step();
        end
        bus.valid_i = 1'b0;
        check("mr_pre_valid", bus.valid_o, 1);
        check("mr_pre_full", bus.full_o, 1);
        #2 rst = 1'b1;
        #1;
        check("mr_result", bus.result_o, 0);
        check("mr_valid", bus.valid_o, 0);
        check("mr_full", bus.full_o, 0);
        check("mr_drop", bus.dropErr_o, 0);
        check("mr_ovf", bus.isOverflow_o, 0);
        check("mr_inx", bus.isInexact_o, 0);
        @(negedge clk);
        rst = 1'b0;
        bus.ready_i = 1'b1;
        for (int j = 0; j < 4; j++) begin
            step();
            check($sformatf("mr_stale%0d", j), bus.valid_o, 0);
        end

        // Randomised traffic against the reference model with random stalls
        pending    = 0;
        drop_model = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            check("rnd_drop", bus.dropErr_o, drop_model);
            rdy = ($urandom_range(0, 9) < 6);
            vld = ($urandom_range(0, 9) < 7);
            drive(vld, 1'($urandom), 8'($urandom), 12'($urandom),
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 15) != 0));
            bus.ready_i = rdy;
            if (vld && pending == 3 && !rdy) drop_model = 1'b1;
            if (bus.valid_o && rdy) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL rnd_extra: got result %0h expected none", bus.result_o);
                end else begin
                    exp_v = sb.pop_front();
                    check("rnd_result", bus.result_o, exp_v[17:2]);
                    check("rnd_ovf", bus.isOverflow_o, exp_v[1]);
                    check("rnd_inx", bus.isInexact_o, exp_v[0]);
                end
                pending--;
            end
            if (vld && !(pending == 3 && !rdy) && !(pending == 2 && !rdy && drop_model && sb.size() == 3)) begin
                sb.push_back(model(bus.s_i, bus.e_i, bus.f_i, bus.isOverflow_i, bus.isUnderflow_i, bus.isToRound_i));
                pending++;
            end
            step();
        end

        // Drain remaining results with a bounded cycle budget
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        for (int c = 0; c < 20 && sb.size() > 0; c++) begin
            if (bus.valid_o) begin
                exp_v = sb.pop_front();
                check("drain_result", bus.result_o, exp_v[17:2]);
                check("drain_ovf", bus.isOverflow_o, exp_v[1]);
                check("drain_inx", bus.isInexact_o, exp_v[0]);
            end
            step();
        end
        check("drain_left", sb.size(), 0);
        check("final_drop", bus.dropErr_o, drop_model);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/lampfpu_log_postnorm.md
# lampfpu_log_postnorm

Post-normalisation and rounding stage directly downstream of the bfloat16 logarithm unit. It buffers the log unit's pre-rounded result (sign, exponent, 12-bit extended mantissa and status flags) in a small FIFO, normalises the mantissa and rounds to nearest-even. It packs a 16-bit bfloat16 word and delivers it through a valid/ready output register. The upstream log unit has no backpressure, so the FIFO absorbs downstream stalls, and any result that cannot be stored is reported through a sticky error flag.

## Interface
- E_DW, 8, exponent width
- F_DW, 7, stored fraction width
- FIFO_DEPTH, 2, input FIFO entries (power of two, ≥2)
- clk  in  1  clock; all registers update on the rising edge
- rst  in  1  reset, asynchronous, active-high
- valid_i  in  1  upstream result valid, single-cycle per result
- s_i  in  1  sign
- e_i  in  E_DW  biased exponent
- f_i  in  F_DW+5  extended mantissa: [11] carry bit, [10] hidden one, [9:3] fraction, [2] guard, [1] round, [0] sticky
- isOverflow_i  in  1  upstream overflow
- isUnderflow_i  in  1  upstream underflow
- isToRound_i  in  1  0 = special value (NaN/Inf), pass through unrounded
- result_o  out  1+E_DW+F_DW  packed bfloat16 {s,e,f}
- valid_o  out  1  result_o valid
- ready_i  in  1  downstream accepts result_o
- isOverflow_o  out  1  result saturated to Inf
- isInexact_o  out  1  G|R|S nonzero on the rounded path
- full_o  out  1  FIFO holds FIFO_DEPTH entries
- dropErr_o  out  1  sticky; a valid_i was lost

## Operation
- FIFO: circular buffer, write/read pointers, count 0..FIFO_DEPTH. Write when valid_i && (!full || pop).
- valid_i && full && !pop: the entry is discarded and dropErr_o is set. It stays set until rst.
- Pop condition: count>0 && (!valid_o || ready_i). The popped head goes through combinational round logic into the output register.
- Output register: loads on pop. Clears valid_o on ready_i && valid_o && !pop. Holds result_o and flags stable while valid_o && !ready_i.
- Round path, evaluated on the head entry, in priority order:
  1. !isToRound: result = {s, e, f[9:3]}, both flags 0.
  2. isOverflow_i: result = {s, 8'hFF, 0}, isOverflow_o=1.
  3. isUnderflow_i: result = {s, 0, 0}, isInexact_o=1.
  4. Otherwise the normal rounded path below.
- Normal path, step 1 (pre-shift): if f[11], shift mantissa right 1 and e+1. The bit shifted out of [3] becomes the guard; the old G|R|S ORs into sticky.
- Normal path, step 2 (round): with G = guard and T = R|S, round up iff G && (T || lsb). Compute on 9 bits: {hidden, fraction}+1.
- Normal path, step 3 (post-round carry): on carry out of the hidden bit, the fraction becomes 0 and e+1.
- Normal path, step 4 (exponent): exponent arithmetic is E_DW+1 bits wide. A final e ≥ 255 gives Inf and isOverflow_o=1.
- Normal path, step 5 (inexact): isInexact_o = G|R|S, evaluated after the pre-shift.
- Denormals are not generated: a hidden bit of 0 with nonzero e is passed unnormalised. The upstream log unit guarantees this does not occur.

## Timing
- Reset values: result_o=0, valid_o=0, isOverflow_o=0, isInexact_o=0, full_o=0, dropErr_o=0. Pointers and count are 0.
- Latency is 2 edges when there is no stall: valid_i sampled at edge k is written to the FIFO; it is popped at edge k+1; valid_o is high after edge k+1.
- There is no FIFO bypass. A write to an empty FIFO is not visible to pop in the same cycle.
- Throughput is one result per cycle with ready_i held high.
- Simultaneous push and pop when full: both occur, count unchanged, no drop.
- Pointer wrap: pointers wrap modulo FIFO_DEPTH. full_o is driven from count, not pointer equality.
- Capacity under stall: FIFO_DEPTH+1 results (FIFO plus output register).
- rst asserted mid-stall: all state clears immediately and asynchronously. In-flight results are discarded. dropErr_o clears.

## Test plan
- Basic rounding: f_i=12'b01_0000000_000, e=127, s=0, isToRound=1 -> result_o=16'h3F80 two edges later, isInexact_o=0.
- Tie-to-even:
  - f_i=01_0000001_100, e=127 -> result_o=16'h3F82, isInexact_o=1.
  - f_i=01_0000000_100 -> result_o=16'h3F80, isInexact_o=1.
- Carries:
  - f_i=01_1111111_110, e=127 -> result_o=16'h4000 (post-round carry).
  - f_i=10_0000000_000, e=127 -> result_o=16'h4000 (pre-shift).
- Overflow and specials:
  - e=254, f_i=01_1111111_111 -> result_o=16'h7F80, isOverflow_o=1.
  - isToRound=0, e=8'hFF, f_i=01_1000000_000 -> result_o=16'h7FC0.
  - isOverflow_i=1, s=1 -> result_o=16'hFF80.
- Backpressure and drop: ready_i=0; four consecutive valid_i with e=127,128,129,130, f_i=01_0000000_000.
  - First three are held: output register plus FIFO, full_o=1.
  - Fourth sets dropErr_o=1.
  - Then ready_i=1 -> outputs 16'h3F80, 16'h4000, 16'h4080 on consecutive cycles.
  - dropErr_o stays 1.
- Reset mid-operation: assert rst asynchronously while valid_o=1 and FIFO holds 2 entries. All outputs go to 0 before the next edge, and no stale result appears after release.
